// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and SPI-pin signals of the two-requester SPI bus arbiter.
// The arbiter connects through 'master'; the environment connects through 'slave'.
interface spi_bus_arbiter_if #(
    parameter int WIDTH = 16
) ();
    logic [1:0]       req;
    logic [WIDTH-1:0] tx0;
    logic [WIDTH-1:0] tx1;
    logic [WIDTH-1:0] rx_data;
    logic [1:0]       done;
    logic             busy;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [1:0]       cs_n;

    modport master (
        input  req, tx0, tx1, miso,
        output rx_data, done, busy, sclk, mosi, cs_n
    );

    modport slave (
        output req, tx0, tx1, miso,
        input  rx_data, done, busy, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI master: round-robin grant, one mode-0 frame per grant,
// and a one-clk done pulse back to the requester that was served.
module spi_bus_arbiter #(
    parameter int DIVIDER = 40,
    parameter int WIDTH   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    spi_bus_arbiter_if.master bus
);
    localparam int CNT_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int EDGE_W = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIVIDER - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [WIDTH-1:0]  tx_sh;
    logic [WIDTH-1:0]  rx_sh;
    logic [WIDTH-1:0]  rx_data_q;
    logic [1:0]        done_q;
    logic              sclk_q;
    logic              gnt;
    logic              last_gnt;
    logic              tick;
    logic              grant;
    logic              gnt_nxt;
    logic              last_edge;

    // NOTE: clocked blocks use <= only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req != 2'b00)   state_nxt = SETUP;
            SETUP:   if (tick)               state_nxt = SHIFT;
            SHIFT:   if (tick && last_edge)  state_nxt = HOLD;
            HOLD:    if (tick)               state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick      = (state != IDLE) && (cnt == CNT_LAST);
        grant     = (state == IDLE) && (bus.req != 2'b00);
        last_edge = (edge_cnt == EDGE_LAST);
        // Under contention the requester not served last wins.
        case (bus.req)
            2'b01:   gnt_nxt = 1'b0;
            2'b10:   gnt_nxt = 1'b1;
            default: gnt_nxt = ~last_gnt;
        endcase
    end

    // Pins are derived from state, so an async reset releases cs_n at once.
    assign bus.busy    = (state != IDLE) || (done_q != 2'b00);
    assign bus.cs_n    = (state == IDLE) ? 2'b11 : (gnt ? 2'b01 : 2'b10);
    assign bus.mosi    = (state != IDLE) && tx_sh[WIDTH-1];
    assign bus.sclk    = sclk_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= '0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data_q <= '0;
            done_q    <= 2'b00;
            sclk_q    <= 1'b0;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
        end else begin
            done_q <= 2'b00;
            if (grant) begin
                gnt      <= gnt_nxt;
                last_gnt <= gnt_nxt;
                tx_sh    <= gnt_nxt ? bus.tx1 : bus.tx0;
                cnt      <= '0;
                edge_cnt <= '0;
                sclk_q   <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    case (state)
                        SHIFT: begin
                            sclk_q   <= ~sclk_q;
                            edge_cnt <= edge_cnt + EDGE_W'(1);
                            if (!sclk_q) rx_sh <= {rx_sh[WIDTH-2:0], bus.miso};
                            else         tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                        end
                        HOLD: begin
                            rx_data_q <= rx_sh;
                            done_q    <= gnt ? 2'b10 : 2'b01;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomised bench for spi_bus_arbiter: a frame-level model predicts grant order,
// pin waveforms, latency and received data for two parameter sets.
module tb_spi_bus_arbiter;
    localparam int DA = 2;
    localparam int WA = 16;
    localparam int DB = 1;
    localparam int WB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst_a, n_rst_b;
    logic [1:0]  req;
    logic [31:0] tx0, tx1, rx_word;
    logic        loop, miso_drv, sel, hold_req;

    spi_bus_arbiter_if #(.WIDTH(WA)) ifa ();
    spi_bus_arbiter_if #(.WIDTH(WB)) ifb ();

    assign ifa.req  = req;
    assign ifa.tx0  = tx0[WA-1:0];
    assign ifa.tx1  = tx1[WA-1:0];
    assign ifa.miso = loop ? ifa.mosi : miso_drv;
    assign ifb.req  = req;
    assign ifb.tx0  = tx0[WB-1:0];
    assign ifb.tx1  = tx1[WB-1:0];
    assign ifb.miso = loop ? ifb.mosi : miso_drv;

    spi_bus_arbiter #(.DIVIDER(DA), .WIDTH(WA)) dut_a (.clk(clk), .n_rst(n_rst_a), .bus(ifa));
    spi_bus_arbiter #(.DIVIDER(DB), .WIDTH(WB)) dut_b (.clk(clk), .n_rst(n_rst_b), .bus(ifb));

    // The monitor watches whichever instance 'sel' picks.
    logic [1:0]  cs_n_m, done_m;
    logic        sclk_m, mosi_m, busy_m, rst_m;
    logic [31:0] rx_m;
    always_comb begin
        if (sel) begin
            cs_n_m = ifb.cs_n; done_m = ifb.done; sclk_m = ifb.sclk;
            mosi_m = ifb.mosi; busy_m = ifb.busy; rst_m = n_rst_b;
            rx_m   = 32'(ifb.rx_data);
        end else begin
            cs_n_m = ifa.cs_n; done_m = ifa.done; sclk_m = ifa.sclk;
            mosi_m = ifa.mosi; busy_m = ifa.busy; rst_m = n_rst_a;
            rx_m   = 32'(ifa.rx_data);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model state
    int          W, D, m_k, m_rises;
    logic        m_act, m_g, m_last;
    logic [31:0] m_tx, m_rxw, m_bits;
    logic [1:0]  p_req;
    logic [31:0] p_tx0, p_tx1;
    logic        p_rst, p_sclk;
    int          gseq[$];

    function automatic logic [31:0] mask();
        return (W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);
    endfunction

    // Called once per negedge; p_* hold what the preceding posedge saw.
    task automatic monitor();
        int ph;
        int lat;
        lat = (2 * W + 2) * D;
        if (!rst_m) begin
            check("reset_pins", 32'({cs_n_m, sclk_m, mosi_m, busy_m, done_m}), 32'({2'b11, 5'b00000}));
            check("reset_rx", rx_m, 32'd0);
            m_act  = 1'b0;
            m_last = 1'b1;
        end else if (!m_act) begin
            if (p_rst && p_req != 2'b00) begin
                m_g     = !p_req[0] || (p_req[1] && !m_last);
                m_last  = m_g;
                m_act   = 1'b1;
                m_k     = 0;
                m_rises = 0;
                m_bits  = '0;
                m_tx    = (m_g ? p_tx1 : p_tx0) & mask();
                m_rxw   = loop ? m_tx : (rx_word & mask());
                miso_drv = m_rxw[W-1];
                gseq.push_back(int'(cs_n_m == 2'b01));
                check("grant_cs", 32'(cs_n_m), 32'(m_g ? 2'b01 : 2'b10));
                check("grant_pins", 32'({sclk_m, mosi_m, busy_m, done_m}),
                      32'({1'b0, m_tx[W-1], 1'b1, 2'b00}));
            end else begin
                check("idle_pins", 32'({cs_n_m, sclk_m, mosi_m, busy_m, done_m}), 32'({2'b11, 5'b00000}));
            end
        end else begin
            m_k++;
            if (sclk_m && !p_sclk) begin
                m_bits = {m_bits[30:0], mosi_m};
                m_rises++;
                if (m_rises < W) miso_drv = m_rxw[W-1-m_rises];
            end
            if (m_k < lat) begin
                ph = m_k / D;
                check("frame_pins", 32'({cs_n_m, sclk_m, busy_m, done_m}),
                      32'({(m_g ? 2'b01 : 2'b10), (ph >= 2 && ph <= 2 * W && ph % 2 == 0), 1'b1, 2'b00}));
            end else begin
                check("done", 32'(done_m), 32'(m_g ? 2'b10 : 2'b01));
                check("rx_data", rx_m, m_rxw);
                check("done_pins", 32'({cs_n_m, sclk_m, mosi_m, busy_m}), 32'({2'b11, 3'b001}));
                check("sclk_pulses", 32'(m_rises), 32'(W));
                check("mosi_bits", m_bits, m_tx);
                m_act = 1'b0;
            end
        end
        p_req  = req;
        p_tx0  = tx0;
        p_tx1  = tx1;
        p_rst  = rst_m;
        p_sclk = sclk_m;
    endtask

    // Requesters drop their req as soon as they see their done pulse.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
        if (!hold_req) req = req & ~done_m;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((req != 2'b00 || m_act) && n < budget) begin
            cycle();
            n++;
        end
        check("quiet_in_budget", 32'(n < budget), 32'd1);
        cycle();
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] seq;
        n_rst_a = 1'b0; n_rst_b = 1'b0;
        req = 2'b00; tx0 = '0; tx1 = '0; rx_word = '0;
        loop = 1'b1; miso_drv = 1'b0; sel = 1'b0; hold_req = 1'b0;
        W = WA; D = DA;
        m_act = 1'b0; m_last = 1'b1; m_g = 1'b0; m_k = 0; m_rises = 0;
        m_tx = '0; m_rxw = '0; m_bits = '0;
        p_req = 2'b00; p_tx0 = '0; p_tx1 = '0; p_rst = 1'b0; p_sclk = 1'b0;
        #1;
        check("reset_t0_cs", 32'(ifa.cs_n), 32'(2'b11));
        cycle(); cycle();
        n_rst_a = 1'b1;
        cycle();

        // Loopback frame from requester 0
        req = 2'b01; tx0 = 32'h0000_A5C3; loop = 1'b1;
        wait_quiet(300);
        check("loopback_rx", rx_m, 32'h0000_A5C3);

        // Requester 1, miso tied high
        req = 2'b10; tx1 = 32'h0000_8001; loop = 1'b0; rx_word = 32'hFFFF_FFFF;
        wait_quiet(300);
        check("miso_high_rx", rx_m, 32'h0000_FFFF);

        // Both requesting, held from reset
        n_rst_a = 1'b0; hold_req = 1'b1; req = 2'b11; loop = 1'b1;
        tx0 = $urandom; tx1 = $urandom;
        gseq.delete();
        cycle(); cycle();
        n_rst_a = 1'b1;
        n = 0;
        while (gseq.size() < 3 && n < 600) begin cycle(); n++; end
        check("rr_in_budget", 32'(n < 600), 32'd1);
        hold_req = 1'b0; req = 2'b00;
        wait_quiet(300);
        seq = (gseq.size() >= 3) ? {gseq[0][0], gseq[1][0], gseq[2][0]} : 3'b111;
        check("rr_sequence", 32'(seq), 32'(3'b010));

        // Reset during the 8th sclk high phase
        req = 2'b01; tx0 = $urandom; loop = 1'b1;
        n = 0;
        while (!(m_act && m_rises == 8) && n < 300) begin cycle(); n++; end
        check("abort_in_budget", 32'(n < 300), 32'd1);
        check("abort_sclk_high", 32'(sclk_m), 32'd1);
        n_rst_a = 1'b0;
        #1;
        check("abort_pins", 32'({cs_n_m, sclk_m, busy_m, done_m}), 32'({2'b11, 4'b0000}));
        cycle(); cycle();
        n_rst_a = 1'b1;
        tx0 = $urandom;
        wait_quiet(300);

        // Mid-frame changes to tx0 and req are ignored
        req = 2'b01; tx0 = $urandom; loop = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        tx0 = ~tx0; req = 2'b00;
        wait_quiet(300);
        check("no_regrant_busy", 32'(busy_m), 32'd0);

        for (int i = 0; i < 12; i++) begin
            req = 2'($urandom_range(1, 3));
            tx0 = $urandom; tx1 = $urandom; rx_word = $urandom;
            loop = 1'($urandom_range(0, 1));
            wait_quiet(400);
        end

        // Fastest configuration: DIVIDER=1, WIDTH=2
        n_rst_a = 1'b0; sel = 1'b1; W = WB; D = DB;
        cycle(); cycle();
        n_rst_b = 1'b1;
        cycle();
        req = 2'b01; tx0 = 32'd2; loop = 1'b1;
        wait_quiet(50);
        check("fast_rx", rx_m, 32'd2);
        for (int i = 0; i < 10; i++) begin
            req = 2'($urandom_range(1, 3));
            tx0 = $urandom; tx1 = $urandom; rx_word = $urandom;
            loop = 1'($urandom_range(0, 1));
            wait_quiet(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter DIVIDER, default 40, clk cycles per SCLK half-period; legal range 1..256.
REQ-002 Parameter WIDTH, default 16, bits per SPI frame; legal range 2..32.
REQ-003 clk  input  1  system clock; all state advances on its rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  level request per requester (0 = ADC, 1 = DAC).
REQ-006 tx0  input  WIDTH  frame data for requester 0, sampled at grant.
REQ-007 tx1  input  WIDTH  frame data for requester 1, sampled at grant.
REQ-008 rx_data  output  WIDTH  last received frame, valid when done pulses, held until next done.
REQ-009 done  output  2  one-clk pulse to the requester whose frame completed.
REQ-010 busy  output  1  high from grant until the done cycle inclusive.
REQ-011 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 mosi  output  1  serial data out, MSB first.
REQ-013 miso  input  1  serial data in, MSB first.
REQ-014 cs_n  output  2  active-low chip select, one per requester, at most one low.

Function
REQ-015 Internal tick counter counts 0..DIVIDER-1 in SETUP, SHIFT and HOLD; a tick occurs at terminal count, then the counter wraps to 0.
REQ-016 States: IDLE, SETUP, SHIFT, HOLD.
REQ-017 IDLE: when any req is high, grant one requester, latch its tx word, drive cs_n[g]=0, mosi=tx[WIDTH-1], busy=1, clear the counter, and go to SETUP, all on the same edge.
REQ-018 Arbitration is round-robin: with a single request, grant it; with both requesting, grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-019 SETUP: on tick, go to SHIFT with sclk=0.
REQ-020 SHIFT: each tick toggles sclk; on a 0->1 tick, shift miso into the rx shift register LSB; on a 1->0 tick, shift the tx register left and drive the new MSB on mosi.
REQ-021 After the WIDTH-th rising edge and its following falling edge (2*WIDTH ticks), go to HOLD with sclk=0.
REQ-022 HOLD: on tick, drive cs_n to all ones, load rx_data from the rx shift register, pulse done[g] for one clk, drop busy, and go to IDLE.
REQ-023 Latency: done is asserted exactly (2*WIDTH+2)*DIVIDER clk cycles after the grant edge.
REQ-024 The block spends at least one clk in IDLE with cs_n all ones between frames; a req still high in IDLE is granted on the next edge (requesters drop req on done).
REQ-025 Changes to req or tx during a frame are ignored; the frame always completes.
REQ-026 mosi is 0 whenever cs_n is all ones; sclk is 0 outside SHIFT.
REQ-027 DIVIDER=1: a tick occurs every clk; the timing in REQ-023 still holds.

Reset
REQ-028 While n_rst=0, independent of clk: state=IDLE, sclk=0, mosi=0, cs_n=2'b11, done=0, busy=0, rx_data=0, counter=0, last-grant=1.
REQ-029 Reset asserted mid-frame aborts the frame immediately: no done pulse, and cs_n returns high without waiting for clk.
REQ-030 After reset release, the first grant occurs on the first clk edge with req nonzero.

Verification
REQ-031 DIVIDER=2, WIDTH=16, req=01, tx0=16'hA5C3, miso looped to mosi -> cs_n=10 for the frame, 16 sclk pulses, done=01 68 clks after grant, rx_data=16'hA5C3.
REQ-032 req=11 held from reset -> grants alternate 0,1,0; each done targets the matching requester; cs_n never 00.
REQ-033 req=10, tx1=16'h8001, miso tied 1 -> mosi bit sequence 1,0x14,1 sampled on sclk rising edges; rx_data=16'hFFFF.
REQ-034 n_rst pulsed low during the 8th sclk high phase -> cs_n=11, sclk=0, busy=0 immediately; no done; the next req starts a full 16-bit frame.
REQ-035 tx0 changed and req dropped mid-frame -> the original word is transmitted, done still pulses, and there is no regrant.
REQ-036 DIVIDER=1, WIDTH=2 -> done 6 clks after grant; sclk high and low phases are 1 clk each.
